// File: rtl/write_port_scheduler.sv
// Write-port scheduler: grants the shared SRAM write path to one port.
// Highest priority wins; round-robin breaks ties; grant held for a packet.
module write_port_scheduler #(
   parameter int num_of_ports      = 16,
   parameter int priority_width    = 3,
   parameter int pack_length_width = 7,
   parameter int sel_width         = 4
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [num_of_ports-1:0]                     ready,
   input  logic [num_of_ports-1:0]                     eop,
   input  logic [num_of_ports*priority_width-1:0]      priority_in,
   input  logic [num_of_ports*pack_length_width-1:0]   pack_length_in,
   input  logic                                        wr_valid,
   output logic [sel_width-1:0]                        select,
   output logic [num_of_ports-1:0]                     grant,
   output logic                                        grant_valid,
   output logic                                        pkt_done,
   output logic                                        len_err
);

   localparam int cw = pack_length_width + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                    state, state_nx;
   logic [sel_width-1:0]      select_nx, rr_ptr, rr_ptr_nx;
   logic [sel_width-1:0]      win, idx;
   logic [num_of_ports-1:0]   grant_nx;
   logic                      grant_valid_nx, pkt_done_nx, len_err_nx;
   logic [cw-1:0]             beat_cnt, beat_cnt_nx, cnt_inc;
   logic [cw-1:0]             len_lat, len_lat_nx;
   logic [priority_width-1:0] max_prio;
   logic                      any_ready, found, sel_eop, last_beat;

   logic [priority_width-1:0] prio [num_of_ports];
   logic [cw-1:0]             plen [num_of_ports];

   // Length field of zero encodes the maximum packet of 2^width beats.
   always_comb begin
      for (int i = 0; i < num_of_ports; i++) begin
         prio[i] = priority_in[i*priority_width +: priority_width];
         if (pack_length_in[i*pack_length_width +: pack_length_width] == '0)
            plen[i] = cw'(1) << pack_length_width;
         else
            plen[i] = {1'b0,
               pack_length_in[i*pack_length_width +: pack_length_width]};
      end
   end

   always_comb begin
      any_ready = |ready;
      max_prio  = '0;
      for (int i = 0; i < num_of_ports; i++) begin
         if (ready[i] && prio[i] > max_prio)
            max_prio = prio[i];
      end
   end

   // Circular scan from rr_ptr picks the first port at the maximum priority.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < num_of_ports; k++) begin
         idx = sel_width'((int'(rr_ptr) + k) % num_of_ports);
         if (!found && ready[idx] && prio[idx] == max_prio) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign cnt_inc   = beat_cnt + cw'(1);
   assign sel_eop   = eop[select];
   assign last_beat = (cnt_inc == len_lat);

   always_comb begin
      state_nx       = state;
      select_nx      = select;
      grant_nx       = grant;
      grant_valid_nx = grant_valid;
      pkt_done_nx    = 1'b0;
      len_err_nx     = 1'b0;
      rr_ptr_nx      = rr_ptr;
      beat_cnt_nx    = beat_cnt;
      len_lat_nx     = len_lat;
      unique case (state)
         IDLE: begin
            select_nx      = '0;
            grant_nx       = '0;
            grant_valid_nx = 1'b0;
            if (any_ready) begin
               state_nx       = GRANT;
               select_nx      = win;
               grant_nx[win]  = 1'b1;
               grant_valid_nx = 1'b1;
               beat_cnt_nx    = '0;
               len_lat_nx     = plen[win];
            end
         end
         GRANT: begin
            if (wr_valid) begin
               beat_cnt_nx = cnt_inc;
               if (sel_eop || last_beat) begin
                  state_nx       = IDLE;
                  select_nx      = '0;
                  grant_nx       = '0;
                  grant_valid_nx = 1'b0;
                  pkt_done_nx    = 1'b1;
                  len_err_nx     = (sel_eop && cnt_inc < len_lat) ||
                                   (!sel_eop && last_beat);
                  if (select == sel_width'(num_of_ports - 1))
                     rr_ptr_nx = '0;
                  else
                     rr_ptr_nx = select + sel_width'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         select      <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         pkt_done    <= 1'b0;
         len_err     <= 1'b0;
         rr_ptr      <= '0;
         beat_cnt    <= '0;
         len_lat     <= '0;
      end else begin
         state       <= state_nx;
         select      <= select_nx;
         grant       <= grant_nx;
         grant_valid <= grant_valid_nx;
         pkt_done    <= pkt_done_nx;
         len_err     <= len_err_nx;
         rr_ptr      <= rr_ptr_nx;
         beat_cnt    <= beat_cnt_nx;
         len_lat     <= len_lat_nx;
      end
   end

endmodule

// File: tb/tb_write_port_scheduler.sv
// Scoreboard bench for write_port_scheduler: directed packets, queued
// expected grants/completions, checked by an independent monitor.
module tb_write_port_scheduler;

   localparam int N  = 16;
   localparam int PW = 3;
   localparam int LW = 7;
   localparam int SW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    ready, eop;
   logic [N*PW-1:0] prio;
   logic [N*LW-1:0] plen;
   logic            wr_valid;
   logic [SW-1:0]   select;
   logic [N-1:0]    grant;
   logic            grant_valid, pkt_done, len_err;

   int errors = 0;
   int checks = 0;
   int exp_sel_q[$];
   int exp_err_q[$];

   write_port_scheduler #(
      .num_of_ports(N), .priority_width(PW),
      .pack_length_width(LW), .sel_width(SW)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready), .eop(eop),
      .priority_in(prio), .pack_length_in(plen), .wr_valid(wr_valid),
      .select(select), .grant(grant), .grant_valid(grant_valid),
      .pkt_done(pkt_done), .len_err(len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act,
                      input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever a grant starts or a packet ends.
   logic gv_q = 1'b0;
   always @(negedge clk) begin : mon
      int s;
      int e;
      if (!rst) begin
         if (grant_valid && !gv_q) begin
            s = (exp_sel_q.size() > 0) ? exp_sel_q.pop_front() : -1;
            chk("grant_select", select, s);
            chk("grant_onehot", grant, (s >= 0) ? (1 << s) : -1);
         end
         if (pkt_done) begin
            e = (exp_err_q.size() > 0) ? exp_err_q.pop_front() : -1;
            chk("len_err", len_err, e);
            chk("done_grant_cleared", grant_valid, 0);
         end
         if (len_err)
            chk("len_err_without_done", pkt_done, 1);
      end
      gv_q = grant_valid;
   end

   task automatic set_port(input int p, input int pv, input int lv);
      prio[p*PW +: PW] = PW'(pv);
      plen[p*LW +: LW] = LW'(lv);
   endtask

   task automatic expect_pkt(input int s, input int e);
      exp_sel_q.push_back(s);
      exp_err_q.push_back(e);
   endtask

   task automatic do_packet(input int port, input int beats,
                            input int eop_beat, input bit gap);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         n++;
         if (grant_valid) ok = 1'b1;
      end
      chk("grant_latency", ok ? n : 99, 1);
      if (!ok) return;
      for (int b = 1; b <= beats; b++) begin
         if (gap) begin
            eop[port] = 1'b1;
            wr_valid  = 1'b0;
            @(negedge clk);
            eop[port] = 1'b0;
         end
         chk("held_before_beat", grant_valid, 1);
         wr_valid  = 1'b1;
         eop[port] = (b == eop_beat);
         @(negedge clk);
         wr_valid  = 1'b0;
         eop[port] = 1'b0;
      end
      chk("done_at_last_beat", pkt_done, 1);
   endtask

   initial begin
      rst = 1'b1; ready = '0; eop = '0; prio = '0; plen = '0;
      wr_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_select", select, 0);
      chk("rst_grant", grant, 0);
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_len_err", len_err, 0);
      rst = 1'b0;
      @(negedge clk);

      // single port, normal completion; rr_ptr -> 1
      set_port(0, 2, 4); ready = 16'h0001;
      expect_pkt(0, 0); do_packet(0, 4, 4, 0);
      ready = '0; @(negedge clk);

      // tie between 0 and 1 resolves to 1 since rr_ptr = 1
      set_port(1, 2, 4); ready = 16'h0003;
      expect_pkt(1, 0); do_packet(1, 4, 4, 0);
      ready = '0; @(negedge clk);

      // priority beats rr_ptr (rr_ptr = 2 points at port 2)
      set_port(2, 3, 1); set_port(8, 5, 2); ready = 16'h0104;
      expect_pkt(8, 0); do_packet(8, 2, 2, 0);
      ready = '0; @(negedge clk);

      // reset at beat 2 (would be the final beat) aborts quietly
      set_port(5, 1, 2); ready = 16'h0020;
      exp_sel_q.push_back(5);
      @(negedge clk);
      chk("abort_grant_up", grant_valid, 1);
      wr_valid = 1'b1; @(negedge clk);
      rst = 1'b1; ready = '0; @(negedge clk);
      chk("abort_grant", grant, 0);
      chk("abort_grant_valid", grant_valid, 0);
      chk("abort_pkt_done", pkt_done, 0);
      chk("abort_len_err", len_err, 0);
      chk("abort_select", select, 0);
      rst = 1'b0; wr_valid = 1'b0;
      @(negedge clk);

      // round-robin from rr_ptr = 0 with ready held across packets
      set_port(1, 4, 2); set_port(5, 4, 2); set_port(9, 4, 2);
      ready = 16'h0222;
      expect_pkt(1, 0); expect_pkt(5, 0);
      expect_pkt(9, 0); expect_pkt(1, 0);
      do_packet(1, 2, 2, 0);
      do_packet(5, 2, 2, 0);
      do_packet(9, 2, 2, 0);
      do_packet(1, 2, 2, 0);
      ready = '0; @(negedge clk);

      // length exhausted without eop
      set_port(3, 0, 3); ready = 16'h0008;
      expect_pkt(3, 1); do_packet(3, 3, 0, 0);
      ready = '0; @(negedge clk);

      // early eop on beat 2 of 6
      set_port(3, 0, 6); ready = 16'h0008;
      expect_pkt(3, 1); do_packet(3, 2, 2, 0);
      ready = '0; @(negedge clk);

      // length field 0 means 128 beats
      set_port(4, 7, 0); ready = 16'h0010;
      expect_pkt(4, 0); do_packet(4, 128, 128, 0);
      ready = '0; @(negedge clk);

      // wr_valid gaps with stray eop do not count or release
      set_port(6, 1, 5); ready = 16'h0040;
      expect_pkt(6, 0); do_packet(6, 5, 5, 1);
      ready = '0;

      repeat (3) @(negedge clk);
      chk("sel_queue_drained", exp_sel_q.size(), 0);
      chk("err_queue_drained", exp_err_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
